// File: rtl/exec_writeback.sv
// Execute/writeback stage: reads two operands from register_file, runs the ALU, writes dst back.
// Optional shift-add multiplier (opcode 8) is built only when EXEC_MUL_EN is defined.
module exec_writeback #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              instValid,
  output logic              instReady,
  input  logic [3:0]        opcode,
  input  logic [ADDR_W-1:0] dstAddr,
  input  logic [ADDR_W-1:0] srcAddr,
  output logic [ADDR_W-1:0] rfDst,
  output logic [ADDR_W-1:0] rfSrc,
  input  logic [DATA_W-1:0] rfDstRead,
  input  logic [DATA_W-1:0] rfSrcRead,
  output logic [DATA_W-1:0] rfDstWrite,
  output logic              rfWriteEnable,
  output logic              done,
  output logic              illegal,
  output logic              zeroFlag,
  output logic              carryFlag,
  output logic [2:0]        stateDbg
);

  localparam int SH_W = $clog2(DATA_W);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    EXEC  = 3'd2,
`ifdef EXEC_MUL_EN
    MUL   = 3'd3,
`endif
    WRITE = 3'd4
  } state_t;

  state_t state, nextState;

  logic [3:0]        opQ;
  logic [ADDR_W-1:0] dstQ, srcQ;
  logic [DATA_W-1:0] aQ, bQ, resultQ;
  logic              isLegal, isWrite, isMul;
  logic [DATA_W:0]   sumW, diffW;
  logic [DATA_W-1:0] aluRes;
  logic              aluCarry;
`ifdef EXEC_MUL_EN
  logic [SH_W-1:0]   mulCnt;
  logic [DATA_W-1:0] mulAcc;
  logic              mulLast;
`endif

  always_comb begin
    isMul   = 1'b0;
    isLegal = (opQ <= 4'd9);
`ifdef EXEC_MUL_EN
    isMul   = (opQ == 4'd8);
`else
    if (opQ == 4'd8) isLegal = 1'b0;
`endif
    isWrite = isLegal && (opQ != 4'd9);
  end

  always_comb begin
    sumW     = {1'b0, aQ} + {1'b0, bQ};
    diffW    = {1'b0, aQ} - {1'b0, bQ};
    aluRes   = bQ;
    aluCarry = 1'b0;
    case (opQ)
      4'd1:       begin aluRes = sumW[DATA_W-1:0];  aluCarry = sumW[DATA_W];  end
      4'd2, 4'd9: begin aluRes = diffW[DATA_W-1:0]; aluCarry = diffW[DATA_W]; end
      4'd3:       aluRes = aQ & bQ;
      4'd4:       aluRes = aQ | bQ;
      4'd5:       aluRes = aQ ^ bQ;
      4'd6:       aluRes = aQ << bQ[SH_W-1:0];
      4'd7:       aluRes = aQ >> bQ[SH_W-1:0];
      default:    aluRes = bQ;
    endcase
  end

`ifdef EXEC_MUL_EN
  assign mulAcc  = resultQ + (bQ[0] ? aQ : '0);
  assign mulLast = (mulCnt == SH_W'(DATA_W - 1));
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= nextState;
  end

  // Handshake: an instruction transfers on a rising edge where instValid && instReady;
  // instReady is high only in IDLE, so instValid in any other state is ignored.
  always_comb begin
    nextState = state;
    case (state)
      IDLE:  if (instValid) nextState = READ;
      READ:  nextState = EXEC;
`ifdef EXEC_MUL_EN
      EXEC:  nextState = isMul ? MUL : WRITE;
      MUL:   if (mulLast) nextState = WRITE;
`else
      EXEC:  nextState = WRITE;
`endif
      WRITE: nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Strobes are gated by reset so a write in WRITE is abandoned on a reset edge.
  always_comb begin
    instReady     = (state == IDLE);
    done          = (state == WRITE) && !reset;
    rfWriteEnable = (state == WRITE) && isWrite && !reset;
    illegal       = (state == WRITE) && !isLegal && !reset;
    stateDbg      = state;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      opQ       <= '0;
      dstQ      <= '0;
      srcQ      <= '0;
      aQ        <= '0;
      bQ        <= '0;
      resultQ   <= '0;
      zeroFlag  <= 1'b0;
      carryFlag <= 1'b0;
`ifdef EXEC_MUL_EN
      mulCnt    <= '0;
`endif
    end else begin
      case (state)
        IDLE: if (instValid) begin
          opQ  <= opcode;
          dstQ <= dstAddr;
          srcQ <= srcAddr;
        end
        READ: begin
          aQ <= rfDstRead;
          bQ <= rfSrcRead;
        end
        EXEC: begin
          if (isMul) begin
`ifdef EXEC_MUL_EN
            resultQ <= '0;
            mulCnt  <= '0;
`endif
          end else if (isLegal) begin
            if (isWrite) resultQ <= aluRes;
            zeroFlag  <= (aluRes == '0);
            carryFlag <= aluCarry;
          end
        end
`ifdef EXEC_MUL_EN
        MUL: begin
          resultQ <= mulAcc;
          aQ      <= aQ << 1;
          bQ      <= bQ >> 1;
          mulCnt  <= mulCnt + 1'b1;
          if (mulLast) begin
            zeroFlag  <= (mulAcc == '0);
            carryFlag <= 1'b0;
          end
        end
`endif
        default: ;
      endcase
    end
  end

  assign rfDst      = dstQ;
  assign rfSrc      = srcQ;
  assign rfDstWrite = resultQ;

endmodule

// File: tb/tb_exec_writeback.sv
// Bench for exec_writeback: behavioural register file, vector table, and reset corner sequences.
module tb_exec_writeback;

  logic        clk = 1'b0;
  logic        reset;
  logic        instValid;
  logic        instReady;
  logic [3:0]  opcode;
  logic [3:0]  dstAddr, srcAddr, rfDst, rfSrc;
  logic [63:0] rfDstRead, rfSrcRead, rfDstWrite;
  logic        rfWriteEnable, done, illegal, zeroFlag, carryFlag;
  logic [2:0]  stateDbg;

  logic [63:0] regs [16];
  logic        pokeEn = 1'b0;
  logic [3:0]  pokeAddr = '0;
  logic [63:0] pokeData = '0;
  int          writeCount = 0;
  int          doneCount = 0;
  int          nChecks = 0;
  int          nPass = 0;

  always #5 clk = ~clk;

  exec_writeback #(.DATA_W(64), .ADDR_W(4)) dut (
    .clk(clk), .reset(reset), .instValid(instValid), .instReady(instReady),
    .opcode(opcode), .dstAddr(dstAddr), .srcAddr(srcAddr),
    .rfDst(rfDst), .rfSrc(rfSrc), .rfDstRead(rfDstRead), .rfSrcRead(rfSrcRead),
    .rfDstWrite(rfDstWrite), .rfWriteEnable(rfWriteEnable), .done(done),
    .illegal(illegal), .zeroFlag(zeroFlag), .carryFlag(carryFlag), .stateDbg(stateDbg)
  );

  // Combinational-read register file model.
  assign rfDstRead = regs[rfDst];
  assign rfSrcRead = regs[rfSrc];

  always @(posedge clk) begin
    if (rfWriteEnable)  regs[rfDst] <= rfDstWrite;
    else if (pokeEn)    regs[pokeAddr] <= pokeData;
    if (rfWriteEnable)  writeCount <= writeCount + 1;
    if (done)           doneCount <= doneCount + 1;
  end

  typedef struct {
    logic [3:0]  op;
    logic [3:0]  dst;
    logic [3:0]  src;
    logic        pre;
    logic [63:0] initDst;
    logic [63:0] initSrc;
    logic [63:0] expReg;
    logic        expWrite;
    logic        expIll;
    logic        expZ;
    logic        expC;
    int          lat;
  } vec_t;

  vec_t vecs [13];

  function automatic vec_t mk(input logic [3:0] op, dst, src, input logic pre,
                              input logic [63:0] iD, iS, eR,
                              input logic eW, eI, eZ, eC, input int lat);
    vec_t v;
    v.op = op; v.dst = dst; v.src = src; v.pre = pre;
    v.initDst = iD; v.initSrc = iS; v.expReg = eR;
    v.expWrite = eW; v.expIll = eI; v.expZ = eZ; v.expC = eC; v.lat = lat;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic poke(input logic [3:0] a, input logic [63:0] d);
    @(negedge clk);
    pokeEn = 1'b1; pokeAddr = a; pokeData = d;
    @(negedge clk);
    pokeEn = 1'b0;
  endtask

  task automatic issue(input logic [3:0] op, input logic [3:0] d, input logic [3:0] s);
    instValid = 1'b1; opcode = op; dstAddr = d; srcAddr = s;
    @(posedge clk);
    #1;
    instValid = 1'b0; opcode = 4'h0; dstAddr = 4'h0; srcAddr = 4'h0;
  endtask

  task automatic runVec(input vec_t v, input int idx);
    int k;
    int doneBefore;
    bit found;
    if (v.pre) begin
      poke(v.dst, v.initDst);
      poke(v.src, v.initSrc);
    end
    @(negedge clk);
    check($sformatf("v%0d_ready_before", idx), 64'(instReady), 64'd1);
    doneBefore = doneCount;
    issue(v.op, v.dst, v.src);
    k = 0;
    found = 1'b0;
    while (!found && k < 100) begin
      @(negedge clk);
      k++;
      if (done) found = 1'b1;
    end
    check($sformatf("v%0d_latency", idx), 64'(k), 64'(v.lat));
    check($sformatf("v%0d_wen", idx), 64'(rfWriteEnable), 64'(v.expWrite));
    check($sformatf("v%0d_rfDst", idx), 64'(rfDst), 64'(v.dst));
    check($sformatf("v%0d_illegal", idx), 64'(illegal), 64'(v.expIll));
    if (v.expWrite) check($sformatf("v%0d_wdata", idx), rfDstWrite, v.expReg);
    @(negedge clk);
    check($sformatf("v%0d_reg", idx), regs[v.dst], v.expReg);
    check($sformatf("v%0d_zero", idx), 64'(zeroFlag), 64'(v.expZ));
    check($sformatf("v%0d_carry", idx), 64'(carryFlag), 64'(v.expC));
    check($sformatf("v%0d_ready_after", idx), 64'(instReady), 64'd1);
    check($sformatf("v%0d_done_pulses", idx), 64'(doneCount - doneBefore), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int wc;
    vecs[0]  = mk(4'd1,  4'd1,  4'd2,  1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 1, 0, 1, 1, 3);
    vecs[1]  = mk(4'd2,  4'd3,  4'd4,  1, 64'd5, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 1, 0, 0, 1, 3);
    vecs[2]  = mk(4'd0,  4'd5,  4'd3,  0, 64'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFE, 1, 0, 0, 0, 3);
    vecs[3]  = mk(4'd9,  4'd4,  4'd4,  0, 64'd0, 64'd0, 64'd7, 0, 0, 1, 0, 3);
    vecs[4]  = mk(4'd12, 4'd2,  4'd1,  0, 64'd0, 64'd0, 64'd1, 0, 1, 1, 0, 3);
    vecs[5]  = mk(4'd3,  4'd8,  4'd9,  1, 64'hF0F0, 64'hFF00, 64'hF000, 1, 0, 0, 0, 3);
    vecs[6]  = mk(4'd4,  4'd8,  4'd9,  0, 64'd0, 64'd0, 64'hFF00, 1, 0, 0, 0, 3);
    vecs[7]  = mk(4'd5,  4'd10, 4'd11, 1, 64'hAAAA, 64'hAAAA, 64'd0, 1, 0, 1, 0, 3);
    vecs[8]  = mk(4'd6,  4'd12, 4'd13, 1, 64'd1, 64'h43, 64'd8, 1, 0, 0, 0, 3);
    vecs[9]  = mk(4'd7,  4'd12, 4'd13, 1, 64'h8000_0000_0000_0000, 64'h3F, 64'd1, 1, 0, 0, 0, 3);
    vecs[10] = mk(4'd1,  4'd14, 4'd15, 1, 64'd2, 64'd3, 64'd5, 1, 0, 0, 0, 3);
`ifdef EXEC_MUL_EN
    vecs[11] = mk(4'd8,  4'd6,  4'd7,  1, 64'h1_0000_0001, 64'd3, 64'h3_0000_0003, 1, 0, 0, 0, 67);
`else
    vecs[11] = mk(4'd8,  4'd6,  4'd7,  1, 64'h1_0000_0001, 64'd3, 64'h1_0000_0001, 0, 1, 0, 0, 3);
`endif
    vecs[12] = mk(4'd2,  4'd14, 4'd15, 1, 64'd0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0, 0, 1, 3);

    // Reset held with a pending instruction: nothing may be accepted.
    reset = 1'b1; instValid = 1'b1; opcode = 4'd1; dstAddr = 4'd1; srcAddr = 4'd2;
    repeat (3) @(negedge clk);
    check("rst_ready", 64'(instReady), 64'd1);
    check("rst_wen", 64'(rfWriteEnable), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    reset = 1'b0; instValid = 1'b0;
    @(negedge clk);
    check("post_rst_ready", 64'(instReady), 64'd1);
    check("post_rst_state", 64'(stateDbg), 64'd0);
    check("post_rst_rfDst", 64'(rfDst), 64'd0);
    check("post_rst_rfSrc", 64'(rfSrc), 64'd0);
    check("post_rst_wdata", rfDstWrite, 64'd0);
    check("post_rst_zero", 64'(zeroFlag), 64'd0);
    check("post_rst_carry", 64'(carryFlag), 64'd0);

    for (int i = 0; i < 13; i++) runVec(vecs[i], i);

    // Reset during EXEC of ADD r1,r2: no write, flags cleared, idle next cycle.
    poke(4'd1, 64'd10);
    poke(4'd2, 64'd20);
    wc = writeCount;
    @(negedge clk);
    issue(4'd1, 4'd1, 4'd2);
    @(negedge clk);
    @(negedge clk);
    check("midexec_state", 64'(stateDbg), 64'd2);
    reset = 1'b1;
    @(negedge clk);
    check("midexec_ready", 64'(instReady), 64'd1);
    check("midexec_carry", 64'(carryFlag), 64'd0);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    check("midexec_r1", regs[1], 64'd10);
    check("midexec_writes", 64'(writeCount - wc), 64'd0);

    // Reset sampled on the edge ending WRITE abandons the write.
    wc = writeCount;
    issue(4'd1, 4'd1, 4'd2);
    repeat (3) @(negedge clk);
    check("rstwrite_state", 64'(stateDbg), 64'd4);
    reset = 1'b1;
    #1;
    check("rstwrite_wen", 64'(rfWriteEnable), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("rstwrite_r1", regs[1], 64'd10);
    check("rstwrite_writes", 64'(writeCount - wc), 64'd0);

    // Recovery: the same ADD now completes.
    runVec(mk(4'd1, 4'd1, 4'd2, 0, 64'd0, 64'd0, 64'd30, 1, 0, 0, 0, 3), 13);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
